// File: rtl/debounced_switch_bank_pkg.sv
// Shared types and sizing helpers for the debounced switch bank.
package debounced_switch_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } hold_state_t;

   // Counter width able to hold values 0..limit-1, never narrower than one bit.
   function automatic int cnt_w(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/debounced_switch_bank_debounce_channel.sv
// One switch channel: synchroniser, debounce filter, hold FSM, event pulses, toggle latch.
module debounce_channel
   import debounced_switch_bank_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT   = 4,
   parameter int LONG_PRESS_LIMIT = 12,
   parameter bit TOGGLE           = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   input  logic clr,
   output logic state_out,
   output logic debounced,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int DB_W   = cnt_w(DEBOUNCE_LIMIT);
   localparam int HOLD_W = cnt_w(LONG_PRESS_LIMIT);

   logic              sync_p0, sync_p1;
   logic [DB_W-1:0]   db_cnt;
   logic              deb_q;
   hold_state_t       hold_st;
   logic [HOLD_W-1:0] hold_cnt;
   logic              long_fired;
   logic              toggle_q;
   logic              db_done, rise_now, fall_now;

   // The FSM reacts on the same edge the debounced level changes.
   assign db_done  = (sync_p1 != debounced) && (db_cnt == DB_W'(DEBOUNCE_LIMIT - 1));
   assign rise_now = db_done & sync_p1;
   assign fall_now = db_done & ~sync_p1;

   assign state_out = TOGGLE ? toggle_q : debounced;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0       <= 1'b0;
         sync_p1       <= 1'b0;
         db_cnt        <= '0;
         debounced     <= 1'b0;
         deb_q         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         hold_st       <= ST_IDLE;
         hold_cnt      <= '0;
         long_fired    <= 1'b0;
         toggle_q      <= 1'b0;
      end else begin
         // synchroniser stage
         sync_p0 <= sw;
         sync_p1 <= sync_p0;

         // debounce stage
         if (sync_p1 == debounced) begin
            db_cnt <= '0;
         end else if (db_done) begin
            debounced <= sync_p1;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end

         // event stage: pulses follow the debounced change by one cycle
         deb_q         <= debounced;
         press_pulse   <= debounced & ~deb_q;
         release_pulse <= ~debounced & deb_q;
         long_pulse    <= 1'b0;

         case (hold_st)
            ST_IDLE: begin
               if (rise_now) begin
                  hold_st  <= ST_HELD;
                  hold_cnt <= '0;
               end
            end
            ST_HELD: begin
               if (fall_now) begin
                  hold_st <= ST_IDLE;
               end else if (hold_cnt == HOLD_W'(LONG_PRESS_LIMIT - 1)) begin
                  long_pulse <= 1'b1;
                  long_fired <= 1'b1;
                  hold_st    <= ST_LONG;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_LONG: begin
               if (fall_now) begin
                  hold_st    <= ST_IDLE;
                  long_fired <= 1'b0;
               end
            end
            default: hold_st <= ST_IDLE;
         endcase

         // Only a short press toggles; a coincident clear takes priority.
         if (clr) begin
            toggle_q <= 1'b0;
         end else if (fall_now && hold_st == ST_HELD && !long_fired) begin
            toggle_q <= ~toggle_q;
         end
      end
   end

endmodule

// File: rtl/debounced_switch_bank.sv
// Bank of independent debounced switch channels with press/release/long-press events.
module debounced_switch_bank
   import debounced_switch_bank_pkg::*;
#(
   parameter int                NUM_CH           = 4,
   parameter int                DEBOUNCE_LIMIT   = 250000,
   parameter int                LONG_PRESS_LIMIT = 12500000,
   parameter logic [NUM_CH-1:0] TOGGLE_MASK      = {NUM_CH{1'b1}}
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic [NUM_CH-1:0] i_Switch,
   input  logic [NUM_CH-1:0] i_Clear,
   output logic [NUM_CH-1:0] o_State,
   output logic [NUM_CH-1:0] o_Debounced,
   output logic [NUM_CH-1:0] o_Press,
   output logic [NUM_CH-1:0] o_Release,
   output logic [NUM_CH-1:0] o_Long_Press
);

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_LIMIT  (DEBOUNCE_LIMIT),
         .LONG_PRESS_LIMIT(LONG_PRESS_LIMIT),
         .TOGGLE          (TOGGLE_MASK[n])
      ) u_ch (
         .clk          (i_Clk),
         .rst          (i_Reset),
         .sw           (i_Switch[n]),
         .clr          (i_Clear[n]),
         .state_out    (o_State[n]),
         .debounced    (o_Debounced[n]),
         .press_pulse  (o_Press[n]),
         .release_pulse(o_Release[n]),
         .long_pulse   (o_Long_Press[n])
      );
   end

endmodule

// File: tb/tb_debounced_switch_bank.sv
// Scoreboard bench for debounced_switch_bank: expected event pulses are queued at stimulus time.
module tb_debounced_switch_bank;

   localparam int NCH  = 4;
   localparam int DBL  = 4;
   localparam int LPL  = 12;
   localparam logic [NCH-1:0] MASK = 4'b0111;

   localparam int EV_PRESS = 0;
   localparam int EV_REL   = 1;
   localparam int EV_LONG  = 2;

   localparam int OFS_DEB   = 2 + DBL;        // drive -> debounced change
   localparam int OFS_PULSE = 3 + DBL;        // drive -> press/release pulse
   localparam int OFS_LONG  = 2 + DBL + LPL;  // press drive -> long pulse

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] sw, clr;
   logic [NCH-1:0] o_state, o_deb, o_press, o_rel, o_long;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;
   logic [NCH-1:0] exp_state = '0;

   typedef struct {
      int cyc;
      int id;
   } ev_t;
   ev_t sb[$];

   debounced_switch_bank #(
      .NUM_CH          (NCH),
      .DEBOUNCE_LIMIT  (DBL),
      .LONG_PRESS_LIMIT(LPL),
      .TOGGLE_MASK     (MASK)
   ) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_Switch    (sw),
      .i_Clear     (clr),
      .o_State     (o_state),
      .o_Debounced (o_deb),
      .o_Press     (o_press),
      .o_Release   (o_rel),
      .o_Long_Press(o_long)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic push_ev(input int c, input int ch, input int kind);
      ev_t e;
      int  i;
      e.cyc = c;
      e.id  = ch * 4 + kind;
      i = 0;
      while (i < sb.size() && (sb[i].cyc < e.cyc || (sb[i].cyc == e.cyc && sb[i].id < e.id))) i++;
      sb.insert(i, e);
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, 32'(o_state), 0);
      check({tag, "_deb"},   32'(o_deb),   0);
      check({tag, "_press"}, 32'(o_press), 0);
      check({tag, "_rel"},   32'(o_rel),   0);
      check({tag, "_long"},  32'(o_long),  0);
   endtask

   // Press channel ch for h cycles, queue its events and check the resulting o_State.
   task automatic press_release(input int ch, input int h);
      int k;
      bit is_long;
      k       = cyc;
      is_long = (h > LPL);
      sw[ch]  = 1'b1;
      push_ev(k + OFS_PULSE, ch, EV_PRESS);
      if (is_long) push_ev(k + OFS_LONG, ch, EV_LONG);
      push_ev(k + h + OFS_PULSE, ch, EV_REL);
      at_cycle(k + OFS_DEB - 1);
      check("pr_deb_before", 32'(o_deb[ch]), 0);
      at_cycle(k + OFS_DEB);
      check("pr_deb_rise", 32'(o_deb[ch]), 1);
      at_cycle(k + h);
      sw[ch] = 1'b0;
      at_cycle(k + h + OFS_PULSE + 1);
      if (!is_long && MASK[ch]) exp_state[ch] = ~exp_state[ch];
      check("pr_state", 32'(o_state[ch]), 32'(exp_state[ch]));
      check("pr_deb_fall", 32'(o_deb[ch]), 0);
   endtask

   // Pops one expected event for every pulse seen.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < NCH; c++) begin
            for (int kd = 0; kd < 3; kd++) begin
               if ((kd == EV_PRESS && o_press[c]) || (kd == EV_REL && o_rel[c]) ||
                   (kd == EV_LONG && o_long[c])) begin
                  if (sb.size() == 0) begin
                     check("unexpected_ev", c * 4 + kd, 32'hFFFF_FFFF);
                  end else begin
                     ev_t e;
                     e = sb.pop_front();
                     check("ev_id", c * 4 + kd, e.id);
                     check("ev_cyc", cyc, e.cyc);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1;
      sw  = '0;
      clr = '0;
      @(negedge clk);
      at_cycle(3);
      rst = 1'b0;
      check_all_zero("reset");
      mon_en = 1'b1;

      // Clean press on ch0 with a 3-cycle dropout; held long enough to go long.
      at_cycle(10);
      k = cyc;
      sw[0] = 1'b1;
      push_ev(k + OFS_PULSE, 0, EV_PRESS);
      push_ev(k + OFS_LONG, 0, EV_LONG);
      push_ev(k + 22 + OFS_PULSE, 0, EV_REL);
      at_cycle(k + OFS_DEB - 1);
      check("s1_deb_pre", 32'(o_deb[0]), 0);
      at_cycle(k + OFS_DEB);
      check("s1_deb_rise", 32'(o_deb[0]), 1);
      at_cycle(k + 10);
      sw[0] = 1'b0;
      at_cycle(k + 13);
      sw[0] = 1'b1;
      at_cycle(k + 20);
      check("s1_glitch_held", 32'(o_deb[0]), 1);
      at_cycle(k + 22);
      sw[0] = 1'b0;
      at_cycle(k + 22 + OFS_PULSE + 2);
      check("s1_long_no_toggle", 32'(o_state[0]), 0);

      // Bounce on ch1, then reset while debounced high, switch still held.
      k = cyc + 2;
      at_cycle(k);
      sw[1] = 1'b1;
      at_cycle(k + 1); sw[1] = 1'b0;
      at_cycle(k + 2); sw[1] = 1'b1;
      at_cycle(k + 3); sw[1] = 1'b0;
      at_cycle(k + 4); sw[1] = 1'b1;
      push_ev(k + 4 + OFS_PULSE, 1, EV_PRESS);
      at_cycle(k + 4 + OFS_DEB - 1);
      check("s2_deb_pre", 32'(o_deb[1]), 0);
      at_cycle(k + 4 + OFS_DEB);
      check("s2_deb_rise", 32'(o_deb[1]), 1);
      at_cycle(k + 13);
      rst = 1'b1;
      at_cycle(k + 14);
      rst = 1'b0;
      check_all_zero("midreset");
      push_ev(k + 14 + 2 + DBL + 1, 1, EV_PRESS);
      at_cycle(k + 24);
      sw[1] = 1'b0;
      push_ev(k + 24 + OFS_PULSE, 1, EV_REL);
      at_cycle(k + 24 + OFS_PULSE);
      exp_state[1] = 1'b1;
      check("s6_short_toggle", 32'(o_state[1]), 1);
      at_cycle(k + 24 + OFS_PULSE + 4);

      // Toggle mode on ch0: three short presses, then a standalone clear.
      press_release(0, 8);
      press_release(0, 8);
      press_release(0, 8);
      clr[0] = 1'b1;
      at_cycle(cyc + 1);
      clr[0] = 1'b0;
      at_cycle(cyc + 1);
      exp_state[0] = 1'b0;
      check("clear_state", 32'(o_state[0]), 0);

      // Long press on ch2 leaves o_State alone.
      at_cycle(cyc + 2);
      press_release(2, 20);

      // Follow mode on ch3 with i_Clear held.
      at_cycle(cyc + 2);
      k = cyc;
      sw[3]  = 1'b1;
      clr[3] = 1'b1;
      push_ev(k + OFS_PULSE, 3, EV_PRESS);
      push_ev(k + 10 + OFS_PULSE, 3, EV_REL);
      at_cycle(k + OFS_DEB - 1);
      check("fol_state_pre", 32'(o_state[3]), 0);
      at_cycle(k + OFS_DEB);
      check("fol_state_rise", 32'(o_state[3]), 1);
      at_cycle(k + 10);
      sw[3] = 1'b0;
      at_cycle(k + 10 + OFS_DEB - 1);
      check("fol_state_hold", 32'(o_state[3]), 1);
      at_cycle(k + 10 + OFS_DEB);
      check("fol_state_fall", 32'(o_state[3]), 0);
      clr[3] = 1'b0;

      // Clear coincident with a short release on ch0.
      at_cycle(cyc + 4);
      k = cyc;
      sw[0] = 1'b1;
      push_ev(k + OFS_PULSE, 0, EV_PRESS);
      push_ev(k + 8 + OFS_PULSE, 0, EV_REL);
      at_cycle(k + 8);
      sw[0] = 1'b0;
      at_cycle(k + 8 + OFS_DEB - 1);
      check("coinc_pre", 32'(o_state[0]), 0);
      clr[0] = 1'b1;
      at_cycle(k + 8 + OFS_DEB);
      clr[0] = 1'b0;
      at_cycle(k + 8 + OFS_DEB + 2);
      check("coinc_clear_wins", 32'(o_state[0]), 0);
      check("final_state", 32'(o_state), 32'(exp_state));

      at_cycle(cyc + 30);
      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
